// File: rtl/mem_c_deskew_pkg.sv
// Shared systolic-array typedefs: deskew FSM states and counter sizing helpers.
// Imported by the deskew top, its lane columns and the interface.
package mem_c_deskew_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } deskew_state_t;

  // The counter must reach 2*DIM-2, the diagonal index of the last element.
  function automatic int cnt_width(input int dim);
    return (dim < 2) ? 1 : $clog2(2 * dim - 1);
  endfunction

  function automatic int row_width(input int dim);
    return (dim < 2) ? 1 : $clog2(dim);
  endfunction

endpackage

// File: rtl/mem_c_deskew_if.sv
// Result-side bundle between the systolic array, the deskew buffer and its reader.
// Cin arrives skewed one cycle per lane; Cout is a combinational row readout.
interface mem_c_deskew_if #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8
);
  import mem_c_deskew_pkg::*;

  localparam int RW = row_width(DIM);

  logic                     en;
  logic                     start;
  logic signed [BITS_C-1:0] Cin  [DIM];
  logic        [RW-1:0]     Crow;
  logic signed [BITS_C-1:0] Cout [DIM];
  logic                     busy;
  logic                     done;

  modport master (
    output en, start, Cin, Crow,
    input  Cout, busy, done
  );

  modport slave (
    input  en, start, Cin, Crow,
    output Cout, busy, done
  );

endinterface

// File: rtl/mem_c_deskew_lane.sv
// One result column: captures lane LANE's skewed stream into rows cnt-LANE.
// Write on the edge after we is seen; read is combinational; no backpressure.
module deskew_lane
  import mem_c_deskew_pkg::*;
#(
  parameter int BITS_C = 16,
  parameter int DIM    = 8,
  parameter int LANE   = 0,
  parameter int CW     = cnt_width(DIM),
  parameter int RW     = row_width(DIM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic        [CW-1:0]     cnt,
  input  logic        [RW-1:0]     row,
  input  logic signed [BITS_C-1:0] din,
  output logic signed [BITS_C-1:0] dout
);

  localparam logic [CW:0] LANE_W = (CW + 1)'(LANE);
  localparam logic [CW:0] DIM_W  = (CW + 1)'(DIM);

  logic signed [BITS_C-1:0] col [DIM];
  logic        [CW:0]       rel;
  logic                     hit;

  // Lane LANE carries row cnt-LANE; outside 0..DIM-1 it carries nothing for us.
  assign rel = {1'b0, cnt} - LANE_W;
  assign hit = we && ({1'b0, cnt} >= LANE_W) && (rel < DIM_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++) begin
        col[r] <= '0;
      end
    end else if (hit) begin
      col[rel[RW-1:0]] <= din;
    end
  end

  assign dout = col[row];

endmodule

// File: rtl/mem_c_deskew.sv
// Deskew buffer for systolic results: 2*DIM-1 enabled edges from start to done.
// en=0 freezes FSM, counter and storage; start is ignored mid-capture.
module mem_c_deskew
  import mem_c_deskew_pkg::*;
#(
  parameter int BITS_C = 16,
  parameter int DIM    = 8
) (
  input logic           clk,
  input logic           rst_n,
  mem_c_deskew_if.slave io
);

  localparam int              CW       = cnt_width(DIM);
  localparam int              RW       = row_width(DIM);
  localparam logic [CW-1:0]   CNT_LAST = CW'(2 * DIM - 2);

  deskew_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we        = 1'b0;
    if (io.en) begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (io.start) begin
            state_nxt = ST_CAPTURE;
            cnt_nxt   = '0;
          end
        end
        ST_CAPTURE: begin
          we = 1'b1;
          if (cnt == CNT_LAST) begin
            state_nxt = ST_DONE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Flag decodes come straight off the state register.
  assign io.busy = (state == ST_CAPTURE);
  assign io.done = (state == ST_DONE);

  for (genvar g = 0; g < DIM; g++) begin : g_lane
    deskew_lane #(
      .BITS_C (BITS_C),
      .DIM    (DIM),
      .LANE   (g),
      .CW     (CW),
      .RW     (RW)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .cnt   (cnt),
      .row   (io.Crow),
      .din   (io.Cin[g]),
      .dout  (io.Cout[g])
    );
  end

endmodule

// File: tb/tb_mem_c_deskew.sv
// Randomised scoreboard bench for mem_c_deskew: expected rows/flags are queued by
// the stimulus and compared by an independent negedge monitor.
module tb_mem_c_deskew;

  localparam int BITS_C = 16;
  localparam int DIM    = 8;
  localparam int STEPS  = 2 * DIM - 1;

  logic clk;
  logic rst_n;

  mem_c_deskew_if #(.BITS_C(BITS_C), .DIM(DIM)) io ();

  mem_c_deskew #(.BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string                   nm;
    logic                    busy;
    logic                    done;
    logic                    chk;
    logic [DIM*BITS_C-1:0]   c;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic obs   = 1'b0;

  // pat[row][col]: what a window delivers; model_c: what the buffer should hold.
  logic signed [BITS_C-1:0] pat     [DIM][DIM];
  logic signed [BITS_C-1:0] model_c [DIM][DIM];

  function automatic logic [DIM*BITS_C-1:0] pack_cout();
    logic [DIM*BITS_C-1:0] v;
    v = '0;
    for (int i = 0; i < DIM; i++) v[i*BITS_C +: BITS_C] = io.Cout[i];
    return v;
  endfunction

  always @(negedge clk) begin
    if (obs) begin
      exp_t e;
      logic [DIM*BITS_C-1:0] got;
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL underflow: monitor observed a cycle with no expected entry");
      end else begin
        e   = q.pop_front();
        got = pack_cout();
        if (io.busy !== e.busy || io.done !== e.done) begin
          n_err++;
          $display("FAIL %s flags: got busy=%b done=%b, want busy=%b done=%b",
                   e.nm, io.busy, io.done, e.busy, e.done);
        end else if (e.chk && got !== e.c) begin
          n_err++;
          $display("FAIL %s Cout row %0d: got %h, want %h", e.nm, io.Crow, got, e.c);
        end
      end
    end
  end

  // k = number of diagonals already written in the current window.
  task automatic push(input string nm, input logic b, input logic d, input logic chk,
                      input int row, input int k);
    exp_t e;
    e.nm = nm; e.busy = b; e.done = d; e.chk = chk; e.c = '0;
    for (int i = 0; i < DIM; i++)
      e.c[i*BITS_C +: BITS_C] = (i + row < k) ? pat[row][i] : model_c[row][i];
    io.Crow = row[$clog2(DIM)-1:0];
    q.push_back(e);
    obs = 1'b1;
  endtask

  task automatic garbage();
    for (int i = 0; i < DIM; i++) io.Cin[i] = BITS_C'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pat(input int mode);
    for (int j = 0; j < DIM; j++)
      for (int i = 0; i < DIM; i++)
        case (mode)
          0:       pat[j][i] = BITS_C'(16 * j + i);
          1:       pat[j][i] = BITS_C'(16'h100 + 16 * j + i);
          2:       pat[j][i] = ((i + j) % 2 == 1) ? 16'sh7FFF : 16'sh8000;
          default: pat[j][i] = BITS_C'($urandom);
        endcase
  endtask

  task automatic readout(input string nm);
    for (int r = 0; r < DIM; r++) begin
      io.en = 1'($urandom); io.start = 1'b0; garbage();
      push(nm, 1'b0, 1'b1, 1'b1, r, 0);
      tick();
    end
    // en low must block a start even in DONE
    io.en = 1'b0; io.start = 1'b1; garbage();
    push({nm, "_hold"}, 1'b0, 1'b1, 1'b1, 3, 0);
    tick();
    io.start = 1'b0;
  endtask

  task automatic run_window(input string nm, input int stall_at, input int stall_len,
                            input int start_at, input int rst_at, input bit rnd_stall);
    io.en = 1'b1; io.start = 1'b1; garbage(); obs = 1'b0;
    tick();
    io.start = 1'b0;
    for (int k = 0; k < STEPS; k++) begin
      int n;
      if (k == rst_at) begin
        rst_n = 1'b0;
        for (int r = 0; r < DIM; r++) for (int i = 0; i < DIM; i++) model_c[r][i] = '0;
        for (int r = 0; r < DIM; r++) begin
          io.en = 1'($urandom); io.start = 1'($urandom); garbage();
          push({nm, "_rst"}, 1'b0, 1'b0, 1'b1, r, 0);
          tick();
        end
        rst_n = 1'b1; io.en = 1'b0; io.start = 1'b0; obs = 1'b0;
        return;
      end
      n = (k == stall_at) ? stall_len : ((rnd_stall && $urandom_range(3) == 0) ? $urandom_range(2, 1) : 0);
      for (int s = 0; s < n; s++) begin
        io.en = 1'b0; io.start = 1'($urandom); garbage();
        push({nm, "_stall"}, 1'b1, 1'b0, 1'b1, $urandom_range(DIM - 1), k);
        tick();
      end
      io.en = 1'b1; io.start = (k == start_at);
      for (int i = 0; i < DIM; i++) begin
        int j = k - i;
        io.Cin[i] = (j >= 0 && j < DIM) ? pat[j][i] : BITS_C'($urandom);
      end
      push({nm, "_cap"}, 1'b1, 1'b0, 1'b1, $urandom_range(DIM - 1), k);
      tick();
    end
    io.start = 1'b0;
    model_c = pat;
    readout(nm);
  endtask

  initial begin
    rst_n = 1'b0; io.en = 1'b0; io.start = 1'b0; io.Crow = '0;
    for (int i = 0; i < DIM; i++) io.Cin[i] = '0;
    for (int r = 0; r < DIM; r++) for (int i = 0; i < DIM; i++) begin
      model_c[r][i] = '0; pat[r][i] = '0;
    end
    tick();
    push("reset", 1'b0, 1'b0, 1'b1, 0, 0);
    tick();
    rst_n = 1'b1;
    // IDLE with en high and no start must not write anything
    for (int r = 0; r < DIM; r++) begin
      io.en = 1'b1; garbage();
      push("idle", 1'b0, 1'b0, 1'b1, r, 0);
      tick();
    end

    set_pat(0); run_window("basic",   -1, 0, -1, -1, 1'b0);
    set_pat(0); run_window("stall",    6, 4, -1, -1, 1'b0);
    set_pat(0); run_window("ign_start", -1, 0, 5, -1, 1'b0);
    set_pat(1); run_window("b2b",     -1, 0, -1, -1, 1'b0);
    set_pat(2); run_window("extreme", -1, 0, -1, -1, 1'b0);
    set_pat(3); run_window("rst_mid", -1, 0, -1, 9, 1'b0);
    // after reset the buffer is zero and IDLE
    io.en = 1'b1; io.start = 1'b0;
    for (int r = 0; r < DIM; r++) begin
      garbage();
      push("post_rst", 1'b0, 1'b0, 1'b1, r, 0);
      tick();
    end
    for (int w = 0; w < 3; w++) begin
      set_pat(3);
      run_window("random", -1, 0, $urandom_range(STEPS - 1), -1, 1'b1);
    end

    obs = 1'b0;
    @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d expected entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_c_deskew.md
MEM_C_DESKEW -- requirements
Module: mem_c_deskew

Interface
REQ-001 SHALL have parameter BITS_C, default 16, meaning width of one result element (signed).
REQ-002 SHALL have parameter DIM, default 8, meaning systolic array dimension (rows = lanes = DIM).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port en  input  1  global advance enable; low = complete stall.
REQ-006 SHALL have port start  input  1  begins a capture window.
REQ-007 SHALL have port Cin  input  signed [BITS_C-1:0] x DIM  skewed result lanes from the array, lane i = column i.
REQ-008 SHALL have port Crow  input  $clog2(DIM)  row select for readout.
REQ-009 SHALL have port Cout  output  signed [BITS_C-1:0] x DIM  deskewed row Crow, element i = column i.
REQ-010 SHALL have port busy  output  1  high while in CAPTURE.
REQ-011 SHALL have port done  output  1  high while in DONE (full matrix held).

Function
REQ-012 SHALL implement FSM states IDLE, CAPTURE, DONE.
REQ-013 SHALL hold a DIM x DIM storage array C[row][col] and a capture counter cnt of width $clog2(2*DIM-1).
REQ-014 SHALL, in IDLE or DONE with en=1 and start=1 at an edge, enter CAPTURE with cnt=0.
REQ-015 SHALL treat lane i as carrying row j during the cycle in which cnt = i+j (first data the cycle after start is sampled).
REQ-016 SHALL, at each edge in CAPTURE with en=1, write Cin[i] into C[cnt-i][i] for every lane i with 0 <= cnt-i <= DIM-1; other entries unchanged.
REQ-017 SHALL increment cnt by 1 per enabled CAPTURE edge; at the edge where cnt = 2*DIM-2 perform the final write and enter DONE.
REQ-018 SHALL make a full capture take exactly 2*DIM-1 enabled edges after the start edge (15 for DIM=8).
REQ-019 SHALL ignore start while in CAPTURE.
REQ-020 SHALL, with en=0, hold state, cnt and storage, and perform no writes, regardless of start or Cin.
REQ-021 SHALL drive Cout combinationally as C[Crow][*] in every state; reads during CAPTURE return current, partially updated contents.
REQ-022 SHALL not clear storage on start; each entry is overwritten exactly once per window.
REQ-023 SHALL drive busy = (state==CAPTURE) and done = (state==DONE), both registered-state decodes with no glitch-generating logic on Cin.
REQ-024 SHALL retain storage and remain in DONE indefinitely until start.

Reset
REQ-025 SHALL, on rst_n low, asynchronously force state=IDLE, cnt=0, all C entries=0; hence busy=0, done=0, Cout=0.
REQ-026 SHALL, on reset during CAPTURE, abandon the window; the next start begins a fresh window.

Structure
REQ-027 SHALL place the FSM state enum in the shared systolic package alongside other array-wide typedefs.
REQ-028 SHALL use one sub-module, deskew_lane, instantiated DIM times via generate, holding one column (DIM entries) and taking lane index as a parameter, cnt and write-enable as inputs.
REQ-029 SHALL keep FSM and counter in mem_c_deskew only.

Verification (DIM=8, BITS_C=16)
REQ-030 SHALL cover basic capture: start, then lane i drives 16*j+i when cnt=i+j -> after 15 edges done=1, Crow=3 gives Cout[i]=48+i.
REQ-031 SHALL cover stall: en=0 for 4 cycles mid-window (cnt=6) with garbage on Cin -> contents identical to REQ-030; done asserts 4 cycles later.
REQ-032 SHALL cover start ignored: start pulsed at cnt=5 -> cnt not reset, done at same edge as REQ-030.
REQ-033 SHALL cover reset mid-operation: rst_n low at cnt=9 -> immediately busy=0, done=0, Cout=0 for all Crow.
REQ-034 SHALL cover back-to-back: start while done=1 with pattern 0x100+16*j+i -> done drops next edge, busy=1, all 64 entries replaced, corner C[7][7]=0x177.
REQ-035 SHALL cover signed extremes: lanes drive 0x8000 and 0x7FFF alternately -> Cout reproduces exact bit patterns, no truncation.
